// File: rtl/fp16_to_fp32_converter.sv
// Streaming IEEE-754 binary16 -> binary32 widening converter.
// Two-stage valid/ready pipeline: S1 decodes the operand, S2 assembles the fp32 result.
module fp16_to_fp32_converter #(
  parameter int CNT_W = 16,
  localparam int FLOAT_LEN = 16,
  localparam int EXP_LEN = 5,
  localparam int MANT_LEN = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOAT_LEN-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic                 out_is_nan,
  output logic                 out_is_inf,
  output logic                 out_was_sub,
  output logic [CNT_W-1:0]     conv_count
);

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } cls_e;

  // Leading zeros of the mantissa; only meaningful for a nonzero input.
  function automatic logic [3:0] lzc10(input logic [MANT_LEN-1:0] m);
    logic [3:0] n;
    logic       found;
    n     = 4'd0;
    found = 1'b0;
    for (int i = MANT_LEN - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) begin
          found = 1'b1;
        end else begin
          n = n + 4'd1;
        end
      end
    end
    return n;
  endfunction

  logic                s1_adv_s;
  logic                s2_adv_s;
  logic                in_xfer_s;
  logic                out_xfer_s;

  logic                s1_valid_q, s1_valid_d;
  logic                s1_sign_q, s1_sign_d;
  cls_e                s1_cls_q, s1_cls_d;
  logic [EXP_LEN-1:0]  s1_exp_q, s1_exp_d;
  logic [MANT_LEN-1:0] s1_mant_q, s1_mant_d;
  logic [3:0]          s1_lz_q, s1_lz_d;

  logic                s2_valid_q, s2_valid_d;
  logic [31:0]         s2_data_q, s2_data_d;
  logic                s2_nan_q, s2_nan_d;
  logic                s2_inf_q, s2_inf_d;
  logic                s2_sub_q, s2_sub_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [31:0]         asm_data_s;
  logic                asm_nan_s;
  logic                asm_inf_s;
  logic                asm_sub_s;
  logic [7:0]          asm_exp_s;
  logic [MANT_LEN-1:0] asm_mant_s;

  // Handshake and advance conditions; in_ready is the only comb path from out_ready.
  always_comb begin
    s2_adv_s   = ~s2_valid_q | out_ready;
    s1_adv_s   = ~s1_valid_q | s2_adv_s;
    in_xfer_s  = in_valid & s1_adv_s;
    out_xfer_s = s2_valid_q & out_ready;
  end

  // Stage 1 next-state: in_data is captured only on an input transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_lz_d    = s1_lz_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (in_xfer_s) begin
      s1_sign_d = in_data[FLOAT_LEN-1];
      s1_exp_d  = in_data[FLOAT_LEN-2 -: EXP_LEN];
      s1_mant_d = in_data[MANT_LEN-1:0];
      s1_lz_d   = lzc10(in_data[MANT_LEN-1:0]);
      if (s1_exp_d == 5'd31) begin
        s1_cls_d = (s1_mant_d == 10'd0) ? CLS_INF : CLS_NAN;
      end else if (s1_exp_d == 5'd0) begin
        s1_cls_d = (s1_mant_d == 10'd0) ? CLS_ZERO : CLS_SUB;
      end else begin
        s1_cls_d = CLS_NORM;
      end
    end else begin
      s1_sign_d = s1_sign_q;
    end
  end

  // Result assembly from the decoded S1 fields.
  always_comb begin
    asm_nan_s  = 1'b0;
    asm_inf_s  = 1'b0;
    asm_sub_s  = 1'b0;
    asm_exp_s  = 8'd0;
    asm_mant_s = 10'd0;
    asm_data_s = 32'd0;
    case (s1_cls_q)
      CLS_INF: begin
        asm_inf_s  = 1'b1;
        asm_data_s = {s1_sign_q, 8'hFF, 23'h000000};
      end
      CLS_NAN: begin
        asm_nan_s  = 1'b1;
        asm_data_s = {s1_sign_q, 8'hFF, 23'h400000};
      end
      CLS_ZERO: begin
        asm_data_s = {s1_sign_q, 31'h00000000};
      end
      CLS_SUB: begin
        // Normalise: shift out the leading one, bias the exponent down by lz.
        asm_sub_s  = 1'b1;
        asm_exp_s  = 8'd112 - {4'd0, s1_lz_q};
        asm_mant_s = s1_mant_q << (s1_lz_q + 4'd1);
        asm_data_s = {s1_sign_q, asm_exp_s, asm_mant_s, 13'h0000};
      end
      CLS_NORM: begin
        asm_exp_s  = {3'd0, s1_exp_q} + 8'd112;
        asm_data_s = {s1_sign_q, asm_exp_s, s1_mant_q, 13'h0000};
      end
      default: begin
        asm_data_s = 32'd0;
      end
    endcase
  end

  // Stage 2 next-state and the output transfer counter.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_nan_d   = s2_nan_q;
    s2_inf_d   = s2_inf_q;
    s2_sub_d   = s2_sub_q;
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = asm_data_s;
        s2_nan_d  = asm_nan_s;
        s2_inf_d  = asm_inf_s;
        s2_sub_d  = asm_sub_s;
      end else begin
        s2_data_d = s2_data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (out_xfer_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= CLS_ZERO;
      s1_exp_q   <= 5'd0;
      s1_mant_q  <= 10'd0;
      s1_lz_q    <= 4'd0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 32'd0;
      s2_nan_q   <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_sub_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_cls_q   <= s1_cls_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_lz_q    <= s1_lz_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_nan_q   <= s2_nan_d;
      s2_inf_q   <= s2_inf_d;
      s2_sub_q   <= s2_sub_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = s1_adv_s;
  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_is_nan  = s2_nan_q;
  assign out_is_inf  = s2_inf_q;
  assign out_was_sub = s2_sub_q;
  assign conv_count  = cnt_q;

endmodule

// File: tb/tb_fp16_to_fp32_converter.sv
// Self-checking bench: directed vectors plus randomized traffic against a value-based fp16 model.
module tb_fp16_to_fp32_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_is_nan;
  logic        out_is_inf;
  logic        out_was_sub;
  logic [15:0] conv_count;

  int n_checks = 0;
  int n_pass = 0;
  int n_sent = 0;
  logic [34:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [34:0] prev_word = 35'd0;
  logic        rand_done;

  fp16_to_fp32_converter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_nan(out_is_nan), .out_is_inf(out_is_inf), .out_was_sub(out_was_sub),
    .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: decode the fp16 value as a real number, re-encode it as fp32.
  function automatic logic [34:0] model(input logic [15:0] h);
    int          e;
    int          m;
    int          ei;
    real         v;
    logic [63:0] b;
    logic [31:0] f;
    logic        nan;
    logic        inf;
    logic        sub;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    nan = 1'b0; inf = 1'b0; sub = 1'b0;
    if (e == 31) begin
      if (m == 0) begin
        inf = 1'b1;
        f = {h[15], 8'hFF, 23'h000000};
      end else begin
        nan = 1'b1;
        f = {h[15], 8'hFF, 23'h400000};
      end
    end else if (e == 0 && m == 0) begin
      f = {h[15], 31'h00000000};
    end else begin
      if (e == 0) begin
        sub = 1'b1;
        v = m * (2.0 ** (-24));
      end else begin
        v = (1.0 + m / 1024.0) * (2.0 ** (e - 15));
      end
      b = $realtobits(v);
      ei = int'(b[62:52]) - 896;
      f = {h[15], ei[7:0], b[51:29]};
    end
    return {nan, inf, sub, f};
  endfunction

  task automatic send(input logic [15:0] d, input logic [34:0] e);
    int n;
    in_valid = 1'b1;
    in_data = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) begin
      exp_q.push_back(e);
      n_sent++;
    end else begin
      check("in_ready_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("conv_count", 64'(conv_count), 64'(n_sent[15:0]));
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard ordering and stability under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold", {28'd0, out_valid, out_is_nan, out_is_inf, out_was_sub, out_data},
              {28'd0, 1'b1, prev_word});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          check("out_word", {29'd0, out_is_nan, out_is_inf, out_was_sub, out_data},
                {29'd0, exp_q.pop_front()});
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_word <= {out_is_nan, out_is_inf, out_was_sub, out_data};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] vec_in[9];
    logic [34:0] vec_out[9];
    vec_in  = '{16'h3C00, 16'hC500, 16'h0001, 16'h0200, 16'h83FF,
                16'h7C00, 16'hFE01, 16'h8000, 16'h7BFF};
    vec_out = '{{3'b000, 32'h3F800000}, {3'b000, 32'hC0A00000}, {3'b001, 32'h33800000},
                {3'b001, 32'h38000000}, {3'b001, 32'hB87FC000}, {3'b010, 32'h7F800000},
                {3'b100, 32'hFFC00000}, {3'b000, 32'h80000000}, {3'b000, 32'h477FE000}};
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;
    out_ready = 1'b1;
    rand_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_flags", 64'({out_is_nan, out_is_inf, out_was_sub}), 64'd0);
    check("rst_conv_count", 64'(conv_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed normals, subnormals and specials.
    for (int i = 0; i < 9; i++) begin
      send(vec_in[i], vec_out[i]);
    end
    drain();

    // Back-to-back stream: eight consecutive out_valid cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [15:0] d;
          d = 16'($urandom);
          send(d, model(d));
        end
      end
      begin
        int run;
        int t;
        run = 0;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        while (out_valid && run < 20) begin
          run++;
          @(negedge clk);
        end
        check("b2b_run", 64'(run), 64'd8);
      end
    join
    drain();

    // Backpressure: two words fill the pipeline, then in_ready drops.
    out_ready = 1'b0;
    send(16'h4000, model(16'h4000));
    send(16'h0010, model(16'h0010));
    in_valid = 1'b1;
    in_data = 16'hBC00;
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("full_in_ready_held", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'hBC00, model(16'hBC00));
    send(16'h7E00, model(16'h7E00));
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(16'h5555, model(16'h5555));
    send(16'h1234, model(16'h1234));
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_conv_count", 64'(conv_count), 64'd0);
    exp_q.delete();
    n_sent = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(16'h3C00, {3'b000, 32'h3F800000});
    drain();

    // Randomized traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [15:0] d;
          int k;
          k = int'($urandom_range(0, 7));
          d = 16'($urandom);
          if (k == 0) begin
            d[14:10] = 5'd0;
          end else if (k == 1) begin
            d[14:10] = 5'd31;
          end else if (k == 2) begin
            d[9:0] = 10'd0;
          end
          send(d, model(d));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
